// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each winner gets one ACCESS cycle; reads add an RDWAIT cycle to capture the data.
module mem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic [1:0]    state_r;
  logic          last_r;
  logic          win_r;
  logic          wr_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          a_ack_r;
  logic          b_ack_r;
  logic          a_rvalid_r;
  logic          b_rvalid_r;
  logic [DW-1:0] a_rdata_r;
  logic [DW-1:0] b_rdata_r;

  logic          grant_s;
  logic          any_req_s;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    any_req_s = a_req | b_req;
    if (a_req && b_req) begin
      grant_s = ~last_r;
    end else if (a_req) begin
      grant_s = SEL_A;
    end else begin
      grant_s = SEL_B;
    end
  end

  // Arbiter FSM, operation latch, and per-requester response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_r     <= SEL_B;
      win_r      <= SEL_A;
      wr_r       <= 1'b0;
      addr_r     <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      a_ack_r    <= 1'b0;
      b_ack_r    <= 1'b0;
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rdata_r  <= {DW{1'b0}};
      b_rdata_r  <= {DW{1'b0}};
    end else begin
      a_ack_r    <= 1'b0;
      b_ack_r    <= 1'b0;
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r <= ACCESS;
            win_r   <= grant_s;
            last_r  <= grant_s;
            wr_r    <= (grant_s == SEL_B) ? b_wr    : a_wr;
            addr_r  <= (grant_s == SEL_B) ? b_addr  : a_addr;
            wdata_r <= (grant_s == SEL_B) ? b_wdata : a_wdata;
            a_ack_r <= (grant_s == SEL_A);
            b_ack_r <= (grant_s == SEL_B);
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r <= wr_r ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          // Memory data is valid now, one cycle after the read-enable cycle.
          if (win_r == SEL_B) begin
            b_rdata_r  <= mem_dout;
            b_rvalid_r <= 1'b1;
          end else begin
            a_rdata_r  <= mem_dout;
            a_rvalid_r <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Enables are gated by rst_n so a reset cycle never touches memory.
  assign mem_ren  = rst_n & (state_r == ACCESS) & ~wr_r;
  assign mem_wen  = rst_n & (state_r == ACCESS) & wr_r;
  assign mem_addr = addr_r;
  assign mem_din  = wdata_r;

  assign a_ack    = a_ack_r;
  assign b_ack    = b_ack_r;
  assign a_rvalid = a_rvalid_r;
  assign b_rvalid = b_rvalid_r;
  assign a_rdata  = a_rdata_r;
  assign b_rdata  = b_rdata_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameters AW = 7 (address width) and DW = 8 (data width), which size the 128 x 8 memory it fronts.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_req  in  1  requester A access request; held until a_ack.
- a_wr  in  1  A operation: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_ack  out  1  one-cycle pulse: A operation issued to memory.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds a new read result.
- a_rdata  out  DW  A read result; holds until the next A read completes.
- b_req, b_wr, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as the A signals, for requester B.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_din  out  DW  memory write data.
- mem_dout  in  DW  memory read data; valid one cycle after the mem_ren cycle.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RDWAIT.
REQ-004 In IDLE with any request asserted, the block SHALL latch the winner ID, the winner's wr/addr/wdata, and move to ACCESS; with no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: a lone request always wins; on a simultaneous request, the requester not granted last wins.
REQ-006 The last-grant pointer SHALL update only on the IDLE-to-ACCESS transition.
REQ-007 In ACCESS, mem_addr and mem_din SHALL equal the latched values, and exactly one of mem_ren or mem_wen SHALL be high, per the latched wr.
REQ-008 In ACCESS, the winner's ack SHALL be high for exactly that one cycle; the other ack SHALL be low.
REQ-009 From ACCESS, a write SHALL return to IDLE and a read SHALL go to RDWAIT.
REQ-010 In RDWAIT, mem_ren and mem_wen SHALL be 0, and the block SHALL register mem_dout into the winner's rdata and pulse the winner's rvalid in the following cycle; the FSM SHALL then return to IDLE.
REQ-011 mem_ren and mem_wen SHALL never be high together, and SHALL be 0 in IDLE and RDWAIT.
REQ-012 Latency, counting from the IDLE cycle in which req is sampled:
- ack asserts at +1.
- The write commits at the end of +1.
- rvalid asserts at +3.
- Throughput is 2 cycles per write and 3 cycles per read.
REQ-013 A req still high in the IDLE cycle after its ack SHALL be treated as a new request, sampled with that cycle's wr/addr/wdata.
REQ-014 Requester inputs that change while the block is in ACCESS or RDWAIT SHALL have no effect on the operation in flight.
REQ-015 Outputs SHALL be decoded from registered state only; the one exception is the rst_n gating in REQ-018.
REQ-016 a_rdata and b_rdata SHALL change only on their own rvalid pulse.

Reset
REQ-017 When rst_n is sampled low, the block SHALL set: state = IDLE, last-grant = B (so A wins the first tie), latched addr/wdata/wr = 0, a_rdata = b_rdata = 0, and all ack/rvalid = 0.
REQ-018 mem_ren and mem_wen SHALL be forced to 0 combinationally whenever rst_n = 0, so no memory access occurs during a reset cycle, including a reset asserted while in ACCESS.
REQ-019 A read aborted by reset SHALL produce no rvalid, and the pending result SHALL be discarded.
REQ-020 After rst_n returns high, the first IDLE cycle SHALL arbitrate normally.

Verification
REQ-021 A writes 0x5A to address 0x10, then A reads 0x10 -> a_ack pulses at +1 of each operation; a_rvalid pulses at +3 of the read with a_rdata = 0x5A; b_ack and b_rvalid stay 0 throughout.
REQ-022 A and B both request in the same cycle, and both hold req across three rounds -> grants alternate A, B, A after reset; mem_ren and mem_wen are never high together.
REQ-023 B writes 0xC3 to 0x7F; A requests during B's ACCESS cycle -> A is granted in the following IDLE; a later B read of 0x7F returns 0xC3 (address wrap boundary exercised).
REQ-024 A read is in progress; A's address and wr change during RDWAIT -> a_rdata holds data from the latched address; memory is unchanged.
REQ-025 rst_n is driven low during an ACCESS write of 0xFF to address 0x20 -> mem_wen = 0 in that cycle; a subsequent read of 0x20 returns the prior contents; all outputs are at their reset values.
REQ-026 B holds req continuously for 4 operations -> B is re-granted every 2 cycles for writes and every 3 cycles for reads, with no idle gap beyond the IDLE cycle.
